// File: rtl/l1_cache_pkg.sv
// Shared state encoding and address-split helpers for the set-associative L1 data cache.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } cacheState_e;

  function automatic int offsetW(input int memDataWidth);
    return $clog2(memDataWidth / 8);
  endfunction

  function automatic int indexW(input int numSets);
    return $clog2(numSets);
  endfunction

  function automatic int tagW(input int addrWidth, input int numSets, input int memDataWidth);
    return addrWidth - indexW(numSets) - offsetW(memDataWidth);
  endfunction

  // Word 0 sits in the most significant lane of the line.
  function automatic int wordLsb(input int memDataWidth, input int wordIdx);
    return memDataWidth - 32 * (wordIdx + 1);
  endfunction

endpackage

// File: rtl/l1_cache_assoc_ctrl.sv
// Miss-handling FSM for the L1 cache: DRAM handshake sequencing and saturating hit/miss counters.
module l1_cache_assoc_ctrl
  import l1_cache_pkg::*;
#(
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs_i,
  input  logic                 hit_i,
  input  logic                 victimDirty_i,
  input  logic                 dramAck_i,
  output logic                 cacheAck_o,
  output logic                 dramCs_o,
  output logic                 dramWe_o,
  output logic                 missStart_o,
  output logic                 install_o,
  output logic [cnt_width-1:0] hitCount_o,
  output logic [cnt_width-1:0] missCount_o
);

  cacheState_e          state_q, state_d;
  logic                 replay_q;
  logic [cnt_width-1:0] hitCount_q, missCount_q;
  logic                 hitInc, missInc;

  // The cycle after REFILL replays the held request, which must not count as a hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      replay_q <= (state_q == REFILL);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cs_i && !hit_i) state_d = victimDirty_i ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (dramAck_i) state_d = ALLOCATE;
      ALLOCATE:  if (dramAck_i) state_d = REFILL;
      REFILL:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cacheAck_o = 1'b0;
    dramCs_o   = 1'b0;
    dramWe_o   = 1'b0;
    install_o  = 1'b0;
    hitInc     = 1'b0;
    missInc    = 1'b0;
    case (state_q)
      IDLE: begin
        cacheAck_o = cs_i && hit_i;
        hitInc     = cs_i && hit_i && !replay_q;
        missInc    = cs_i && !hit_i;
      end
      WRITEBACK: begin
        dramCs_o = 1'b1;
        dramWe_o = 1'b1;
      end
      ALLOCATE: begin
        dramCs_o  = 1'b1;
        install_o = dramAck_i;
      end
      default: ;
    endcase
    missStart_o = missInc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (hitInc && (hitCount_q != '1))   hitCount_q  <= hitCount_q + 1'b1;
      if (missInc && (missCount_q != '1)) missCount_q <= missCount_q + 1'b1;
    end
  end

  assign hitCount_o  = hitCount_q;
  assign missCount_o = missCount_q;

endmodule

// File: rtl/l1_cache_assoc.sv
// N-way set-associative write-back, write-allocate L1 data cache: tag/data arrays and datapath.
module l1_cache_assoc
  import l1_cache_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int cpu_data_width = 32,
  parameter int mem_data_width = 256,
  parameter int num_sets       = 32,
  parameter int num_ways       = 2,
  parameter int cnt_width      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [addr_width-1:0]     cache_addr,
  input  logic                      cache_cs,
  input  logic                      cache_we,
  output logic                      cache_ack,
  input  logic [cpu_data_width-1:0] cache_data_i,
  output logic [cpu_data_width-1:0] cache_data_o,
  output logic [addr_width-1:0]     dram_addr,
  output logic                      dram_cs,
  output logic                      dram_we,
  input  logic                      dram_ack,
  input  logic [mem_data_width-1:0] dram_data_i,
  output logic [mem_data_width-1:0] dram_data_o,
  output logic [cnt_width-1:0]      hit_count,
  output logic [cnt_width-1:0]      miss_count
);

  localparam int OffW     = offsetW(mem_data_width);
  localparam int IdxW     = indexW(num_sets);
  localparam int TagW     = tagW(addr_width, num_sets, mem_data_width);
  localparam int WayW     = (num_ways > 1) ? $clog2(num_ways) : 1;
  localparam int WordSelW = OffW - 2;
  localparam int LineIdxW = $clog2(mem_data_width);

  logic [num_ways-1:0]       valid_q     [num_sets];
  logic [num_ways-1:0]       dirty_q     [num_sets];
  logic [WayW-1:0]           victimPtr_q [num_sets];
  logic [TagW-1:0]           tag_q       [num_sets][num_ways];
  logic [mem_data_width-1:0] line_q      [num_sets][num_ways];

  logic [TagW-1:0]     reqTag, missTag_q;
  logic [IdxW-1:0]     reqIdx, missIdx_q;
  logic [WordSelW-1:0] reqWord;
  logic [LineIdxW-1:0] wordBase;
  logic [WayW-1:0]     hitWay, victimWay, missWay_q;
  logic                hit, freeFound, victimDirty;
  logic                missStart, install, writeHit;
  logic                unusedByteBits;

  assign reqTag         = cache_addr[addr_width-1 -: TagW];
  assign reqIdx         = cache_addr[OffW +: IdxW];
  assign reqWord        = cache_addr[2 +: WordSelW];
  assign wordBase       = LineIdxW'(wordLsb(mem_data_width, int'(reqWord)));
  assign unusedByteBits = ^cache_addr[1:0];

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[reqIdx][w] && (tag_q[reqIdx][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WayW'(w);
      end
    end
  end

  // An empty way is always preferred; round-robin only applies to full sets.
  always_comb begin
    freeFound = 1'b0;
    victimWay = victimPtr_q[reqIdx];
    for (int w = 0; w < num_ways; w++) begin
      if (!freeFound && !valid_q[reqIdx][w]) begin
        freeFound = 1'b1;
        victimWay = WayW'(w);
      end
    end
  end

  assign victimDirty = valid_q[reqIdx][victimWay] && dirty_q[reqIdx][victimWay];
  assign writeHit    = cache_ack && cache_we;

  l1_cache_assoc_ctrl #(.cnt_width(cnt_width)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .cs_i         (cache_cs),
    .hit_i        (hit),
    .victimDirty_i(victimDirty),
    .dramAck_i    (dram_ack),
    .cacheAck_o   (cache_ack),
    .dramCs_o     (dram_cs),
    .dramWe_o     (dram_we),
    .missStart_o  (missStart),
    .install_o    (install),
    .hitCount_o   (hit_count),
    .missCount_o  (miss_count)
  );

  // Miss context is latched so the fill lands correctly even if the CPU drops its request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missTag_q <= '0;
      missIdx_q <= '0;
      missWay_q <= '0;
    end else if (missStart) begin
      missTag_q <= reqTag;
      missIdx_q <= reqIdx;
      missWay_q <= victimWay;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s]     <= '0;
        dirty_q[s]     <= '0;
        victimPtr_q[s] <= '0;
      end
    end else if (install) begin
      valid_q[missIdx_q][missWay_q] <= 1'b1;
      dirty_q[missIdx_q][missWay_q] <= 1'b0;
      if (&valid_q[missIdx_q])
        victimPtr_q[missIdx_q] <= (victimPtr_q[missIdx_q] == WayW'(num_ways - 1)) ?
                                  '0 : victimPtr_q[missIdx_q] + 1'b1;
    end else if (writeHit) begin
      dirty_q[reqIdx][hitWay] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      line_q[missIdx_q][missWay_q] <= dram_data_i;
      tag_q[missIdx_q][missWay_q]  <= missTag_q;
    end else if (writeHit) begin
      line_q[reqIdx][hitWay][wordBase +: cpu_data_width] <= cache_data_i;
    end
  end

  assign cache_data_o = line_q[reqIdx][hitWay][wordBase +: cpu_data_width];

  always_comb begin
    dram_addr   = '0;
    dram_data_o = '0;
    if (dram_cs && dram_we) begin
      dram_addr   = {tag_q[missIdx_q][missWay_q], missIdx_q, {OffW{1'b0}}};
      dram_data_o = line_q[missIdx_q][missWay_q];
    end else if (dram_cs) begin
      dram_addr = {missTag_q, missIdx_q, {OffW{1'b0}}};
    end
  end

endmodule

// File: tb/tb_l1_cache_assoc.sv
// Bench for l1_cache_assoc: directed scenarios plus random traffic checked against a per-set cache model.
module tb_l1_cache_assoc;

  localparam int NSETS  = 32;
  localparam int NWAYS  = 2;
  localparam int CNTW   = 4;
  localparam int CNTMAX = (1 << CNTW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cache_addr;
  logic         cache_cs, cache_we, cache_ack;
  logic [31:0]  cache_data_i, cache_data_o;
  logic [31:0]  dram_addr;
  logic         dram_cs, dram_we, dram_ack;
  logic [255:0] dram_data_i, dram_data_o;
  logic [CNTW-1:0] hit_count, miss_count;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [255:0] data;
    int           cycles;
  } dramTxn_t;

  typedef struct {
    bit           valid;
    bit           dirty;
    logic [21:0]  tag;
    logic [255:0] line;
  } mEntry_t;

  dramTxn_t     dramLog[$];
  dramTxn_t     expTxn[$];
  mEntry_t      mCache [NSETS][NWAYS];
  int           mPtr [NSETS];
  int           mHits, mMisses;
  logic [255:0] mem [logic [31:0]];
  bit           dramHold;
  int           checks, errors;

  l1_cache_assoc #(.cnt_width(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cache_addr  (cache_addr),
    .cache_cs    (cache_cs),
    .cache_we    (cache_we),
    .cache_ack   (cache_ack),
    .cache_data_i(cache_data_i),
    .cache_data_o(cache_data_o),
    .dram_addr   (dram_addr),
    .dram_cs     (dram_cs),
    .dram_we     (dram_we),
    .dram_ack    (dram_ack),
    .dram_data_i (dram_data_i),
    .dram_data_o (dram_data_o),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] memRead(input logic [31:0] a);
    logic [255:0] r;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++)
      r[255-32*k -: 32] = (a * 32'd2654435761) ^ (32'h0101_0101 * 32'(k + 1));
    return r;
  endfunction

  function automatic int satInc(input int v);
    return (v >= CNTMAX) ? CNTMAX : v + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < NWAYS; w++)
        mCache[s][w] = '{valid: 1'b0, dirty: 1'b0, tag: '0, line: '0};
      mPtr[s] = 0;
    end
    mHits   = 0;
    mMisses = 0;
  endtask

  // Whole-request view: lookup, optional victim write-back, fill, then the word access itself.
  task automatic modelAccess(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             output bit hit, output logic [31:0] rdata);
    int set, word, way, victim;
    logic [21:0] tag;
    logic [255:0] line;
    logic [31:0] lineAddr;
    bit allValid;
    set      = int'(addr[9:5]);
    word     = int'(addr[4:2]);
    tag      = addr[31:10];
    lineAddr = {addr[31:5], 5'b0};
    expTxn.delete();
    way = -1;
    for (int w = 0; w < NWAYS; w++)
      if (mCache[set][w].valid && mCache[set][w].tag == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      mHits = satInc(mHits);
    end else begin
      mMisses = satInc(mMisses);
      victim = -1;
      for (int w = 0; w < NWAYS; w++)
        if (victim < 0 && !mCache[set][w].valid) victim = w;
      allValid = (victim < 0);
      if (allValid) victim = mPtr[set];
      if (mCache[set][victim].valid && mCache[set][victim].dirty)
        expTxn.push_back('{addr: {mCache[set][victim].tag, addr[9:5], 5'b0}, we: 1'b1,
                           data: mCache[set][victim].line, cycles: 0});
      expTxn.push_back('{addr: lineAddr, we: 1'b0, data: '0, cycles: 0});
      mCache[set][victim] = '{valid: 1'b1, dirty: 1'b0, tag: tag, line: memRead(lineAddr)};
      if (allValid) mPtr[set] = (mPtr[set] + 1) % NWAYS;
      way = victim;
    end
    line = mCache[set][way].line;
    if (we) begin
      line[255-32*word -: 32] = wdata;
      mCache[set][way].line  = line;
      mCache[set][way].dirty = 1'b1;
    end
    rdata = line[255-32*word -: 32];
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    bit expHit, acked;
    logic [31:0] expData;
    int cycles, expCycles;
    modelAccess(addr, we, wdata, expHit, expData);
    dramLog.delete();
    @(negedge clk);
    cache_addr   = addr;
    cache_we     = we;
    cache_data_i = wdata;
    cache_cs     = 1'b1;
    cycles = 0;
    acked  = 1'b0;
    rdata  = '0;
    while (!acked && cycles < 100) begin
      #1;
      if (cache_ack === 1'b1) begin
        acked = 1'b1;
        rdata = cache_data_o;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    @(negedge clk);
    cache_cs = 1'b0;
    checkOutput("ackSeen", acked, 1'b1);
    checkOutput("hitOrMiss", (cycles == 0), expHit);
    if (!we) checkOutput("readData", rdata, expData);
    checkOutput("dramTxnCount", dramLog.size(), expTxn.size());
    expCycles = 2;
    for (int i = 0; i < dramLog.size() && i < expTxn.size(); i++) begin
      checkOutput("dramAddr", dramLog[i].addr, expTxn[i].addr);
      checkOutput("dramWe", dramLog[i].we, expTxn[i].we);
      if (expTxn[i].we) checkOutput("dramWbData", dramLog[i].data, expTxn[i].data);
      expCycles += dramLog[i].cycles;
    end
    if (!expHit && acked) checkOutput("missLatency", cycles, expCycles);
    checkOutput("hitCount", hit_count, mHits);
    checkOutput("missCount", miss_count, mMisses);
  endtask

  // DRAM model: acks each request after 1-3 cycles, logging what the cache presented.
  initial begin : dramResponder
    int csCycles;
    int ackDelay;
    bit wasAck;
    dram_ack    = 1'b0;
    dram_data_i = '0;
    csCycles    = 0;
    ackDelay    = 0;
    forever begin
      @(negedge clk);
      wasAck   = dram_ack;
      dram_ack = 1'b0;
      if (!rst) begin
        csCycles = 0;
      end else if (dram_cs === 1'b1) begin
        csCycles++;
        if (!wasAck && !dramHold && csCycles > ackDelay) begin
          dramLog.push_back('{addr: dram_addr, we: dram_we, data: dram_data_o, cycles: csCycles});
          if (dram_we) mem[dram_addr] = dram_data_o;
          else dram_data_i = memRead(dram_addr);
          dram_ack = 1'b1;
          csCycles = 0;
          ackDelay = $urandom_range(2, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0]  rd, addr;
    logic [255:0] line;
    bit           h, sawAck;
    checks       = 0;
    errors       = 0;
    dramHold     = 1'b0;
    cache_cs     = 1'b0;
    cache_we     = 1'b0;
    cache_addr   = '0;
    cache_data_i = '0;
    modelReset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstAck", cache_ack, 1'b0);
    checkOutput("rstDramCs", dram_cs, 1'b0);
    checkOutput("rstDramWe", dram_we, 1'b0);
    checkOutput("rstDramAddr", dram_addr, 32'h0);
    checkOutput("rstDramData", dram_data_o, 256'h0);
    checkOutput("rstHitCount", hit_count, 4'h0);
    checkOutput("rstMissCount", miss_count, 4'h0);
    rst = 1'b1;

    applyStimulus(32'h0000_0040, 1'b0, 32'h0, rd);
    line = memRead(32'h0000_0040);
    checkOutput("coldWord0", rd, line[255:224]);
    checkOutput("coldMiss", miss_count, 4'd1);
    checkOutput("coldHit", hit_count, 4'd0);

    applyStimulus(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, rd);
    applyStimulus(32'h0000_0044, 1'b0, 32'h0, rd);
    checkOutput("writeReadBack", rd, 32'hDEAD_BEEF);
    checkOutput("twoHits", hit_count, 4'd2);

    applyStimulus(32'h0000_0440, 1'b0, 32'h0, rd);
    applyStimulus(32'h0000_0840, 1'b0, 32'h0, rd);
    checkOutput("evictTxns", dramLog.size(), 2);
    if (dramLog.size() == 2) begin
      line = dramLog[0].data;
      checkOutput("evictWbAddr", dramLog[0].addr, 32'h0000_0040);
      checkOutput("evictWbWe", dramLog[0].we, 1'b1);
      checkOutput("evictWbWord", line[223:192], 32'hDEAD_BEEF);
      checkOutput("evictFillAddr", dramLog[1].addr, 32'h0000_0840);
    end

    // Reset while the fill is outstanding.
    dramHold = 1'b1;
    @(negedge clk);
    cache_addr = 32'h0000_1060;
    cache_we   = 1'b0;
    cache_cs   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("allocCs", dram_cs, 1'b1);
    checkOutput("allocWe", dram_we, 1'b0);
    checkOutput("allocAddr", dram_addr, 32'h0000_1060);
    rst = 1'b0;
    #1;
    checkOutput("rstMidCs", dram_cs, 1'b0);
    checkOutput("rstMidAck", cache_ack, 1'b0);
    checkOutput("rstMidMissCount", miss_count, 4'd0);
    cache_cs = 1'b0;
    modelReset();
    @(negedge clk);
    dramHold = 1'b0;
    rst      = 1'b1;
    applyStimulus(32'h0000_1060, 1'b0, 32'h0, rd);
    checkOutput("reMissCount", miss_count, 4'd1);

    // Request withdrawn during ALLOCATE.
    dramLog.delete();
    modelAccess(32'h0000_2080, 1'b0, 32'h0, h, rd);
    @(negedge clk);
    cache_addr = 32'h0000_2080;
    cache_we   = 1'b0;
    cache_cs   = 1'b1;
    @(negedge clk);
    cache_cs = 1'b0;
    sawAck   = 1'b0;
    repeat (8) begin
      #1;
      if (cache_ack === 1'b1) sawAck = 1'b1;
      @(negedge clk);
    end
    checkOutput("dropNoAck", sawAck, 1'b0);
    checkOutput("dropInstall", dramLog.size(), 1);
    checkOutput("dropMissCount", miss_count, mMisses);
    applyStimulus(32'h0000_2084, 1'b0, 32'h0, rd);

    for (int i = 0; i < 16; i++) applyStimulus(32'h0000_2088, 1'b0, 32'h0, rd);
    checkOutput("hitSaturate", hit_count, 4'hF);

    for (int i = 0; i < 80; i++) begin
      addr = (32'($urandom_range(3, 0)) << 10) | (32'($urandom_range(3, 0)) << 5) |
             (32'($urandom_range(7, 0)) << 2);
      applyStimulus(addr, 1'($urandom_range(1, 0)), $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
